// File: rtl/fram_drv_if.sv
// Command/response bundle between the FRAM self-test sequencer and the FM24CLxx driver.
interface fram_drv_if;
  logic       drv_start;
  logic [7:0] drv_mem_address;
  logic [7:0] drv_data_in;
  logic       drv_write_enable;
  logic       drv_read_enable;
  logic       drv_busy;
  logic [7:0] drv_data_out;
  logic       drv_rd_valid;

  modport master (
    output drv_start, drv_mem_address, drv_data_in, drv_write_enable, drv_read_enable,
    input  drv_busy, drv_data_out, drv_rd_valid
  );

  modport slave (
    input  drv_start, drv_mem_address, drv_data_in, drv_write_enable, drv_read_enable,
    output drv_busy, drv_data_out, drv_rd_valid
  );
endinterface

// File: rtl/fram_test_sequencer.sv
// FRAM self-test: one write pass of addr^PATTERN_SEED, one read-back pass with compare,
// reporting pass/timeout, error count and the first failing address.
module fram_test_sequencer #(
  parameter int         NUM_BYTES    = 256,
  parameter logic [7:0] START_ADDR   = 8'h00,
  parameter logic [7:0] PATTERN_SEED = 8'hA5,
  parameter int         BUSY_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [8:0]       err_count,
  output logic [7:0]       first_err_addr,
  fram_drv_if.master       drv
);

  localparam int         TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [8:0] IDX_LAST = 9'(NUM_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ISSUE = 4'd1,
    WR_WBUSY = 4'd2,
    WR_WDONE = 4'd3,
    WR_NEXT  = 4'd4,
    RD_ISSUE = 4'd5,
    RD_WBUSY = 4'd6,
    RD_WDONE = 4'd7,
    RD_NEXT  = 4'd8,
    FINISH   = 4'd9
  } state_t;

  function automatic logic [7:0] pattern_byte(input logic [7:0] a);
    return a ^ PATTERN_SEED;
  endfunction

  state_t        state_r, state_s;
  logic [7:0]    addr_r, addr_s;
  logic [8:0]    idx_r, idx_s;
  logic [7:0]    data_in_r, data_in_s;
  logic          start_r, start_s;
  logic          we_r, we_s;
  logic          re_r, re_s;
  logic          done_r, done_s;
  logic          pass_r, pass_s;
  logic          timeout_r, timeout_s;
  logic [8:0]    err_count_r, err_count_s;
  logic [7:0]    first_err_r, first_err_s;
  logic [TW-1:0] wait_cnt_r, wait_cnt_s;
  logic [7:0]    rd_byte_r, rd_byte_s;
  logic          got_r, got_s;
  logic          abort_s;
  logic          tmo_hit_s;

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    idx_s       = idx_r;
    data_in_s   = data_in_r;
    done_s      = 1'b0;
    pass_s      = pass_r;
    timeout_s   = timeout_r;
    err_count_s = err_count_r;
    first_err_s = first_err_r;
    wait_cnt_s  = wait_cnt_r;
    rd_byte_s   = rd_byte_r;
    got_s       = got_r;
    abort_s     = 1'b0;
    tmo_hit_s   = (wait_cnt_r == TMO_LAST);

    case (state_r)
      IDLE: begin
        if (run) begin
          err_count_s = 9'd0;
          first_err_s = 8'h00;
          pass_s      = 1'b0;
          timeout_s   = 1'b0;
          addr_s      = START_ADDR;
          idx_s       = 9'd0;
          data_in_s   = pattern_byte(START_ADDR);
          state_s     = WR_ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      WR_ISSUE: begin
        wait_cnt_s = '0;
        state_s    = WR_WBUSY;
      end
      RD_ISSUE: begin
        wait_cnt_s = '0;
        got_s      = 1'b0;
        state_s    = RD_WBUSY;
      end
      WR_WBUSY, RD_WBUSY: begin
        if (drv.drv_busy) begin
          wait_cnt_s = '0;
          state_s    = (state_r == WR_WBUSY) ? WR_WDONE : RD_WDONE;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + TW'(1);
        end
      end
      WR_WDONE, RD_WDONE: begin
        if (!drv.drv_busy) begin
          state_s = (state_r == WR_WDONE) ? WR_NEXT : RD_NEXT;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          wait_cnt_s = wait_cnt_r + TW'(1);
        end
      end
      WR_NEXT: begin
        if (idx_r == IDX_LAST) begin
          addr_s  = START_ADDR;
          idx_s   = 9'd0;
          state_s = RD_ISSUE;
        end else begin
          addr_s  = addr_r + 8'd1;
          idx_s   = idx_r + 9'd1;
          state_s = WR_ISSUE;
        end
        data_in_s = pattern_byte(addr_s);
      end
      RD_NEXT: begin
        // A missing strobe counts the same as a wrong byte; err_count==0 marks "no error yet".
        if (!got_r || (rd_byte_r != pattern_byte(addr_r))) begin
          if (err_count_r != 9'h1FF) begin
            err_count_s = err_count_r + 9'd1;
          end else begin
            err_count_s = err_count_r;
          end
          if (err_count_r == 9'd0) begin
            first_err_s = addr_r;
          end else begin
            first_err_s = first_err_r;
          end
        end else begin
          err_count_s = err_count_r;
        end
        if (idx_r == IDX_LAST) begin
          pass_s  = (err_count_s == 9'd0);
          done_s  = 1'b1;
          state_s = FINISH;
        end else begin
          addr_s  = addr_r + 8'd1;
          idx_s   = idx_r + 9'd1;
          state_s = RD_ISSUE;
        end
        data_in_s = pattern_byte(addr_s);
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if ((state_r == RD_WBUSY || state_r == RD_WDONE) && drv.drv_rd_valid && !got_r) begin
      rd_byte_s = drv.drv_data_out;
      got_s     = 1'b1;
    end else begin
      rd_byte_s = rd_byte_s;
    end

    if (abort_s) begin
      state_s   = IDLE;
      timeout_s = 1'b1;
      pass_s    = 1'b0;
      done_s    = 1'b1;
    end else begin
      timeout_s = timeout_s;
    end

    start_s = (state_s == WR_ISSUE) || (state_s == RD_ISSUE);
    we_s    = (state_s == WR_ISSUE) || (state_s == WR_WBUSY) ||
              (state_s == WR_WDONE) || (state_s == WR_NEXT);
    re_s    = (state_s == RD_ISSUE) || (state_s == RD_WBUSY) ||
              (state_s == RD_WDONE) || (state_s == RD_NEXT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= 8'h00;
      idx_r       <= 9'd0;
      data_in_r   <= 8'h00;
      start_r     <= 1'b0;
      we_r        <= 1'b0;
      re_r        <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
      err_count_r <= 9'd0;
      first_err_r <= 8'h00;
      wait_cnt_r  <= '0;
      rd_byte_r   <= 8'h00;
      got_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      idx_r       <= idx_s;
      data_in_r   <= data_in_s;
      start_r     <= start_s;
      we_r        <= we_s;
      re_r        <= re_s;
      done_r      <= done_s;
      pass_r      <= pass_s;
      timeout_r   <= timeout_s;
      err_count_r <= err_count_s;
      first_err_r <= first_err_s;
      wait_cnt_r  <= wait_cnt_s;
      rd_byte_r   <= rd_byte_s;
      got_r       <= got_s;
    end
  end

  assign done                 = done_r;
  assign pass                 = pass_r;
  assign timeout              = timeout_r;
  assign err_count            = err_count_r;
  assign first_err_addr       = first_err_r;
  assign drv.drv_start        = start_r;
  assign drv.drv_mem_address  = addr_r;
  assign drv.drv_data_in      = data_in_r;
  assign drv.drv_write_enable = we_r;
  assign drv.drv_read_enable  = re_r;

endmodule

// File: tb/tb_fram_test_sequencer.sv
// Directed bench for fram_test_sequencer with a behavioural FM24CLxx driver model per instance.
module tb_fram_test_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_a = 1'b0;
  logic run_b = 1'b0;
  logic log_clr = 1'b0;
  logic corrupt_en = 1'b0;
  logic drop_en = 1'b0;
  logic stuck_en = 1'b0;
  logic [7:0] corrupt_addr = 8'h00;
  logic [7:0] drop_addr = 8'h00;

  logic done_a, pass_a, timeout_a, done_b, pass_b, timeout_b;
  logic [8:0] err_a, err_b;
  logic [7:0] first_a, first_b;

  int n_cmp = 0;
  int n_err = 0;

  fram_drv_if ifa ();
  fram_drv_if ifb ();

  always #5 clk = ~clk;

  fram_test_sequencer #(.NUM_BYTES(4), .START_ADDR(8'h10), .PATTERN_SEED(8'hA5), .BUSY_TIMEOUT(1024))
  dut_a (.clk(clk), .rst_n(rst_n), .run(run_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
         .err_count(err_a), .first_err_addr(first_a), .drv(ifa));

  fram_test_sequencer #(.NUM_BYTES(4), .START_ADDR(8'hFE), .PATTERN_SEED(8'hA5), .BUSY_TIMEOUT(1024))
  dut_b (.clk(clk), .rst_n(rst_n), .run(run_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
         .err_count(err_b), .first_err_addr(first_b), .drv(ifb));

  // Driver model A: busy 2 cycles after start, write/read strobe inside busy, fault knobs.
  logic [7:0] mem_a [256];
  int ph_a, wcnt_a, rdn_a;
  logic we_l_a;
  logic [7:0] addr_l_a, din_l_a;
  logic [7:0] wlog_addr [16];
  logic [7:0] wlog_data [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      ph_a <= 0;
      ifa.drv_busy <= 1'b0;
      ifa.drv_rd_valid <= 1'b0;
      ifa.drv_data_out <= 8'h00;
    end else begin
      ifa.drv_rd_valid <= 1'b0;
      if (ph_a == 0) begin
        if (ifa.drv_start) begin
          ph_a <= 1;
          we_l_a <= ifa.drv_write_enable;
          addr_l_a <= ifa.drv_mem_address;
          din_l_a <= ifa.drv_data_in;
          if (ifa.drv_read_enable) rdn_a <= rdn_a + 1;
        end
      end else if (ph_a == 1) begin
        ifa.drv_busy <= 1'b1;
        ph_a <= 2;
      end else if (ph_a == 2) begin
        if (we_l_a) begin
          mem_a[addr_l_a] <= din_l_a;
          if (wcnt_a < 16) begin
            wlog_addr[wcnt_a] <= addr_l_a;
            wlog_data[wcnt_a] <= din_l_a;
          end
          wcnt_a <= wcnt_a + 1;
        end else if (!(drop_en && addr_l_a == drop_addr)) begin
          ifa.drv_rd_valid <= 1'b1;
          ifa.drv_data_out <= (corrupt_en && addr_l_a == corrupt_addr) ? 8'h00 : mem_a[addr_l_a];
        end
        ph_a <= 3;
      end else if (ph_a == 3) begin
        ph_a <= 4;
      end else begin
        if (!(stuck_en && we_l_a && wcnt_a == 3)) begin
          ifa.drv_busy <= 1'b0;
          ph_a <= 0;
        end
      end
    end
    if (log_clr) begin
      wcnt_a <= 0;
      rdn_a <= 0;
    end
  end

  // Driver model B: ideal FRAM, logs every issued address.
  logic [7:0] mem_b [256];
  int ph_b, scnt_b;
  logic we_l_b;
  logic [7:0] addr_l_b, din_l_b;
  logic [7:0] slog_b [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      ph_b <= 0;
      ifb.drv_busy <= 1'b0;
      ifb.drv_rd_valid <= 1'b0;
      ifb.drv_data_out <= 8'h00;
    end else begin
      ifb.drv_rd_valid <= 1'b0;
      if (ph_b == 0) begin
        if (ifb.drv_start) begin
          ph_b <= 1;
          we_l_b <= ifb.drv_write_enable;
          addr_l_b <= ifb.drv_mem_address;
          din_l_b <= ifb.drv_data_in;
          if (scnt_b < 16) slog_b[scnt_b] <= ifb.drv_mem_address;
          scnt_b <= scnt_b + 1;
        end
      end else if (ph_b == 1) begin
        ifb.drv_busy <= 1'b1;
        ph_b <= 2;
      end else if (ph_b == 2) begin
        if (we_l_b) begin
          mem_b[addr_l_b] <= din_l_b;
        end else begin
          ifb.drv_rd_valid <= 1'b1;
          ifb.drv_data_out <= mem_b[addr_l_b];
        end
        ph_b <= 3;
      end else begin
        ifb.drv_busy <= 1'b0;
        ph_b <= 0;
      end
    end
    if (log_clr) scnt_b <= 0;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp = n_cmp + 1;
    if (obs !== exp_v) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_logs();
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic pulse_run(input bit sel_b);
    @(negedge clk);
    if (sel_b) run_b = 1'b1; else run_a = 1'b1;
    @(negedge clk);
    run_a = 1'b0;
    run_b = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit sel_b, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (sel_b ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    logic [7:0] exp_addr [4];
    logic [7:0] exp_addr_b [8];
    int guard;
    exp_addr = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_addr_b = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01};

    log_clr = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    log_clr = 1'b0;
    @(negedge clk);
    check_val("rst_flags", {28'd0, done_a, pass_a, timeout_a, ifa.drv_start}, 32'd0);
    check_val("rst_err", {23'd0, err_a}, 32'd0);
    check_val("rst_bus", {14'd0, ifa.drv_mem_address, ifa.drv_data_in, ifa.drv_write_enable, ifa.drv_read_enable}, 32'd0);

    // 1: ideal model
    clear_logs();
    pulse_run(1'b0);
    wait_done("t1_done", 1'b0, 400);
    check_val("t1_pass", {31'd0, pass_a}, 32'd1);
    check_val("t1_err", {23'd0, err_a}, 32'd0);
    check_val("t1_tmo", {31'd0, timeout_a}, 32'd0);
    check_val("t1_first", {24'd0, first_a}, 32'd0);
    check_val("t1_nwr", wcnt_a, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("t1_waddr", {24'd0, wlog_addr[i]}, {24'd0, exp_addr[i]});
    end
    check_val("t1_wd0", {24'd0, wlog_data[0]}, 32'h0000_00B5);
    check_val("t1_wd1", {24'd0, wlog_data[1]}, 32'h0000_00B4);
    check_val("t1_wd2", {24'd0, wlog_data[2]}, 32'h0000_00B7);
    check_val("t1_wd3", {24'd0, wlog_data[3]}, 32'h0000_00B6);
    @(negedge clk);
    check_val("t1_done_pulse", {31'd0, done_a}, 32'd0);
    check_val("t1_pass_hold", {31'd0, pass_a}, 32'd1);

    // 2: corrupted read at 8'h12
    corrupt_addr = 8'h12;
    corrupt_en = 1'b1;
    clear_logs();
    pulse_run(1'b0);
    wait_done("t2_done", 1'b0, 400);
    check_val("t2_err", {23'd0, err_a}, 32'd1);
    check_val("t2_first", {24'd0, first_a}, 32'h0000_0012);
    check_val("t2_pass", {31'd0, pass_a}, 32'd0);
    corrupt_en = 1'b0;

    // 3: driver stuck busy after the third write
    stuck_en = 1'b1;
    clear_logs();
    pulse_run(1'b0);
    wait_done("t3_done", 1'b0, 3000);
    check_val("t3_tmo", {31'd0, timeout_a}, 32'd1);
    check_val("t3_pass", {31'd0, pass_a}, 32'd0);
    check_val("t3_err", {23'd0, err_a}, 32'd0);
    check_val("t3_nwr", wcnt_a, 32'd3);
    check_val("t3_nrd", rdn_a, 32'd0);
    stuck_en = 1'b0;
    repeat (10) @(negedge clk);

    // 4: no read strobe at 8'h11
    drop_addr = 8'h11;
    drop_en = 1'b1;
    clear_logs();
    pulse_run(1'b0);
    wait_done("t4_done", 1'b0, 400);
    check_val("t4_err", {23'd0, err_a}, 32'd1);
    check_val("t4_first", {24'd0, first_a}, 32'h0000_0011);
    check_val("t4_pass", {31'd0, pass_a}, 32'd0);
    check_val("t4_tmo", {31'd0, timeout_a}, 32'd0);
    drop_en = 1'b0;

    // 5: address wrap FE,FF,00,01
    clear_logs();
    pulse_run(1'b1);
    wait_done("t5_done", 1'b1, 400);
    check_val("t5_pass", {31'd0, pass_b}, 32'd1);
    check_val("t5_err", {23'd0, err_b}, 32'd0);
    check_val("t5_nstart", scnt_b, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_val("t5_addr", {24'd0, slog_b[i]}, {24'd0, exp_addr_b[i]});
    end

    // 6: reset in RD_WDONE, then a full re-run
    clear_logs();
    pulse_run(1'b0);
    guard = 0;
    while (!(ifa.drv_read_enable && ifa.drv_busy) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    while (ifa.drv_busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check_val("t6_reach_rd", {31'd0, (guard < 400)}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t6_rst_flags", {27'd0, done_a, pass_a, timeout_a, ifa.drv_start, ifa.drv_read_enable}, 32'd0);
    check_val("t6_rst_bus", {15'd0, ifa.drv_mem_address, ifa.drv_data_in, ifa.drv_write_enable}, 32'd0);
    check_val("t6_rst_err", {15'd0, err_a, first_a}, 32'd0);
    rst_n = 1'b1;
    clear_logs();
    pulse_run(1'b0);
    wait_done("t6_done", 1'b0, 400);
    check_val("t6_pass", {31'd0, pass_a}, 32'd1);
    check_val("t6_nwr", wcnt_a, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
